// File: rtl/error_poly_sampler_if.sv
// Random-beat handshake and shared BRAM write port of the error polynomial sampler.
// The slave modport is the sampler side; the master modport is the beat source and BRAM owner.
interface error_poly_sampler_if #(
  parameter int LOGN = 13,
  parameter int ETA  = 21
);
  logic                start;
  logic [2*ETA+1:0]    rnd_data;
  logic                rnd_valid;
  logic                rnd_ready;
  logic [LOGN-1:0]     error_bram_wr_addr;
  logic [1:0]          v_bram_wr_data;
  logic [5:0]          e1_bram_wr_data;
  logic                error_bram_wea;
  logic                busy;
  logic                done;

  modport slave (
    input  start, rnd_data, rnd_valid,
    output rnd_ready, error_bram_wr_addr, v_bram_wr_data, e1_bram_wr_data,
           error_bram_wea, busy, done
  );

  modport master (
    output start, rnd_data, rnd_valid,
    input  rnd_ready, error_bram_wr_addr, v_bram_wr_data, e1_bram_wr_data,
           error_bram_wea, busy, done
  );
endinterface

// File: rtl/error_poly_sampler.sv
// Samples one ternary v and one centred-binomial e1 coefficient per random beat
// and writes them to BRAM addresses 0..N-1 through a two-stage pipeline.
module error_poly_sampler #(
  parameter int N    = 8192,
  parameter int LOGN = 13,
  parameter int ETA  = 21
) (
  input  logic                 clk,
  input  logic                 rst,
  error_poly_sampler_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [LOGN-1:0] LAST_ADDR = LOGN'(N - 1);

  state_t          state_r;
  state_t          state_s;
  logic            accept_s;
  logic [LOGN-1:0] issue_cnt_r;
  logic            s1_valid_r;
  logic [1:0]      s1_v_r;
  logic [4:0]      s1_pa_r;
  logic [4:0]      s1_pb_r;
  logic [LOGN-1:0] s1_addr_r;
  logic            wea_r;
  logic [LOGN-1:0] addr_r;
  logic [1:0]      v_data_r;
  logic [5:0]      e1_data_r;

  function automatic logic [4:0] popcount(input logic [ETA-1:0] bits);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < ETA; i++) begin
      cnt = cnt + {4'd0, bits[i]};
    end
    return cnt;
  endfunction

  function automatic logic [1:0] map_v(input logic [1:0] bits);
    logic [1:0] res;
    case (bits)
      2'b01:   res = 2'b01;
      2'b10:   res = 2'b11;
      default: res = 2'b00;
    endcase
    return res;
  endfunction

  // Sign+magnitude of pa-pb; equal counts give +0, so no negative zero.
  function automatic logic [5:0] to_sign_mag(input logic [4:0] pa, input logic [4:0] pb);
    logic [5:0] res;
    if (pa >= pb) begin
      res = {1'b0, pa - pb};
    end else begin
      res = {1'b1, pb - pa};
    end
    return res;
  endfunction

  // Beat acceptance and next-state decode.
  always_comb begin
    accept_s = (state_r == ST_RUN) && bus.rnd_valid;
    state_s  = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) state_s = ST_RUN;
        else           state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (accept_s && (issue_cnt_r == LAST_ADDR)) state_s = ST_DRAIN;
        else                                        state_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (wea_r && (addr_r == LAST_ADDR)) state_s = ST_DONE;
        else                                state_s = ST_DRAIN;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // Issue counter: index of the next beat to accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  issue_cnt_r <= '0;
    else if ((state_r == ST_IDLE) && bus.start) issue_cnt_r <= '0;
    else if (accept_s)                        issue_cnt_r <= issue_cnt_r + {{(LOGN-1){1'b0}}, 1'b1};
    else                                      issue_cnt_r <= issue_cnt_r;
  end

  // Stage 1: capture v bits and both popcounts of the accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_v_r     <= 2'b00;
      s1_pa_r    <= 5'd0;
      s1_pb_r    <= 5'd0;
      s1_addr_r  <= '0;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_v_r    <= bus.rnd_data[1:0];
        s1_pa_r   <= popcount(bus.rnd_data[ETA+1:2]);
        s1_pb_r   <= popcount(bus.rnd_data[2*ETA+1:ETA+2]);
        s1_addr_r <= issue_cnt_r;
      end
    end
  end

  // Stage 2: map to sign+magnitude and register the BRAM write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wea_r     <= 1'b0;
      addr_r    <= '0;
      v_data_r  <= 2'b00;
      e1_data_r <= 6'd0;
    end else begin
      wea_r <= s1_valid_r;
      if (s1_valid_r) begin
        addr_r    <= s1_addr_r;
        v_data_r  <= map_v(s1_v_r);
        e1_data_r <= to_sign_mag(s1_pa_r, s1_pb_r);
      end
    end
  end

  assign bus.rnd_ready          = (state_r == ST_RUN);
  assign bus.busy               = (state_r != ST_IDLE);
  assign bus.done               = (state_r == ST_DONE);
  assign bus.error_bram_wea     = wea_r;
  assign bus.error_bram_wr_addr = addr_r;
  assign bus.v_bram_wr_data     = v_data_r;
  assign bus.e1_bram_wr_data    = e1_data_r;

endmodule

// File: tb/tb_error_poly_sampler.sv
// Randomized scoreboard bench for error_poly_sampler (N=8): a driver pushes expected
// writes from a reference model, a monitor pops and compares every BRAM write.
module tb_error_poly_sampler;
  localparam int N    = 8;
  localparam int LOGN = 3;
  localparam int ETA  = 21;

  typedef struct {
    logic [LOGN-1:0] addr;
    logic [1:0]      v;
    logic [5:0]      e1;
    longint          t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  exp_t sb[$];
  exp_t mon_e;
  longint          last_wr_time = 0;
  logic [LOGN-1:0] last_wr_addr = '0;

  error_poly_sampler_if #(.LOGN(LOGN), .ETA(ETA)) bus ();

  error_poly_sampler #(.N(N), .LOGN(LOGN), .ETA(ETA)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [43:0] rand44();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[43:0];
  endfunction

  // Reference: v table and e1 = popcount(a) - popcount(b) in sign+magnitude.
  function automatic exp_t model(input logic [43:0] d);
    exp_t e;
    int   df;
    df = $countones(d[22:2]) - $countones(d[43:23]);
    case (d[1:0])
      2'b01:   e.v = 2'b01;
      2'b10:   e.v = 2'b11;
      default: e.v = 2'b00;
    endcase
    if (df < 0) e.e1 = {1'b1, 5'(-df)};
    else        e.e1 = {1'b0, 5'(df)};
    e.addr = '0;
    e.t    = 0;
    return e;
  endfunction

  function automatic logic [43:0] directed(input int i);
    logic [43:0] d;
    case (i)
      0:       d = {21'h000000, 21'h1FFFFF, 2'b01};
      1:       d = {21'h1FFFFF, 21'h000000, 2'b10};
      2:       d = {21'h00001F, 21'h00001F, 2'b00};
      3:       d = {21'h00001F, 21'h00001F, 2'b11};
      4:       d = {21'h000001, 21'h000003, 2'b01};
      default: d = rand44();
    endcase
    return d;
  endfunction

  function automatic logic [31:0] all_outs();
    return {19'd0, bus.error_bram_wea, bus.error_bram_wr_addr, bus.v_bram_wr_data,
            bus.e1_bram_wr_data, bus.busy, bus.done, bus.rnd_ready};
  endfunction

  // Monitor: every write must match the head of the scoreboard at its expected time.
  always @(negedge clk) begin
    if (bus.error_bram_wea === 1'b1) begin
      check("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("wr_addr", 32'(bus.error_bram_wr_addr), 32'(mon_e.addr));
        check("v_data", 32'(bus.v_bram_wr_data), 32'(mon_e.v));
        check("e1_data", 32'(bus.e1_bram_wr_data), 32'(mon_e.e1));
        check("wr_time_offset", 32'($time - mon_e.t), 32'd0);
      end
      last_wr_time = $time;
      last_wr_addr = bus.error_bram_wr_addr;
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      check("done_after_last_write", 32'($time - last_wr_time), 32'd10);
      check("done_last_addr", 32'(last_wr_addr), 32'(N - 1));
      check("done_sb_empty", 32'(sb.size()), 32'd0);
      check("busy_with_done", 32'(bus.busy), 32'd1);
    end
  end

  // mode 0 directed, 1 random stream, 2 fixed stalls + start poke, 3 random stalls.
  task automatic run_poly(input int mode, input int abort_after);
    int          beats = 0;
    int          gap   = 0;
    int          guard = 0;
    int          waited = 0;
    logic [43:0] cur;
    exp_t        e;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    while (beats < N && guard < 200) begin
      guard++;
      if (gap > 0) begin
        cur = rand44();
        bus.rnd_valid = 1'b0;
        gap--;
      end else begin
        cur = (mode == 0) ? directed(beats) : rand44();
        bus.rnd_valid = 1'b1;
      end
      bus.rnd_data = cur;
      bus.start    = (mode == 2 && beats == 4);
      check("rnd_ready_in_run", 32'(bus.rnd_ready), 32'd1);
      check("busy_in_run", 32'(bus.busy), 32'd1);
      @(posedge clk);
      if (bus.rnd_valid) begin
        e      = model(cur);
        e.addr = LOGN'(beats);
        e.t    = $time + 15;
        sb.push_back(e);
        beats++;
        if (mode == 2 && (beats == 3 || beats == 6)) gap = 3;
        else if (mode == 3 && $urandom_range(0, 2) == 0) gap = $urandom_range(1, 3);
        else gap = 0;
      end
      if (abort_after > 0 && beats == abort_after) begin
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        check("abort_outputs_zero", all_outs(), 32'd0);
        @(negedge clk);
        check("abort_held_zero", all_outs(), 32'd0);
        rst = 1'b0;
        bus.rnd_valid = 1'b0;
        bus.start     = 1'b0;
        return;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("beats_accepted", 32'(beats), 32'(N));
    bus.rnd_valid = 1'b1;
    bus.rnd_data  = rand44();
    check("rnd_ready_after_last", 32'(bus.rnd_ready), 32'd0);
    while (bus.done !== 1'b1 && waited < 10) begin
      @(negedge clk);
      bus.rnd_data = rand44();
      waited++;
    end
    check("done_seen", 32'(bus.done), 32'd1);
    check("done_latency", 32'(waited), 32'd2);
    @(negedge clk);
    bus.rnd_valid = 1'b0;
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("busy_after_done", 32'(bus.busy), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int done_before;
    bus.start     = 1'b0;
    bus.rnd_valid = 1'b0;
    bus.rnd_data  = '0;
    repeat (3) @(negedge clk);
    check("in_reset_outputs", all_outs(), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.rnd_valid = 1'($urandom_range(0, 1));
      bus.rnd_data  = rand44();
      @(negedge clk);
      check("idle_outputs", all_outs(), 32'd0);
    end
    bus.rnd_valid = 1'b0;
    run_poly(0, 0);
    run_poly(1, 0);
    run_poly(2, 0);
    run_poly(3, 0);
    run_poly(3, 0);
    done_before = done_cnt;
    @(negedge clk);
    run_poly(1, 4);
    repeat (6) @(negedge clk);
    check("no_done_after_abort", 32'(done_cnt), 32'(done_before));
    check("idle_after_abort", all_outs(), 32'd0);
    run_poly(0, 0);
    repeat (3) @(negedge clk);
    check("done_pulse_count", 32'(done_cnt), 32'd6);
    check("sb_empty_end", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
